// File: rtl/sram_port_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction fetch and data load/store.
// Data wins ties except after STARVE_LIMIT consecutive data grants with fetch pending.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_INST,
        G_DATA
    } grant_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state, state_d;
    grant_t      grant, grant_d;
    logic [3:0]  starve_cnt, starve_cnt_d;
    logic        wr_d;
    logic [3:0]  wstrb_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic        pick_inst;

    // Fetch wins only when alone or once data has starved it for LIMIT grants.
    assign pick_inst = inst_req && (!data_req || (starve_cnt == LIMIT));

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state;
        grant_d      = grant;
        starve_cnt_d = starve_cnt;
        wr_d         = mem_wr;
        wstrb_d      = mem_wstrb;
        addr_d       = mem_addr;
        wdata_d      = mem_wdata;

        case (state)
            S_IDLE: begin
                if (inst_req || data_req) begin
                    state_d = S_REQ;
                    if (pick_inst) begin
                        grant_d      = G_INST;
                        starve_cnt_d = '0;
                        addr_d       = inst_addr;
                        wr_d         = 1'b0;
                        wstrb_d      = '0;
                        wdata_d      = '0;
                    end else begin
                        grant_d = G_DATA;
                        addr_d  = data_addr;
                        wr_d    = data_wr;
                        wstrb_d = data_wstrb;
                        wdata_d = data_wdata;
                        if (inst_req && (starve_cnt != LIMIT))
                            starve_cnt_d = starve_cnt + 4'd1;
                    end
                end
            end
            S_REQ: begin
                if (mem_addr_ok)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_data_ok) begin
                    state_d = S_IDLE;
                    grant_d = G_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            grant      <= G_NONE;
            starve_cnt <= '0;
            mem_wr     <= 1'b0;
            mem_wstrb  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            starve_cnt <= starve_cnt_d;
            mem_wr     <= wr_d;
            mem_wstrb  <= wstrb_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
        end
    end

    // Handshakes are decoded from registered state, so reset silences them at once.
    assign mem_req      = (state == S_REQ);
    assign busy         = (state != S_IDLE);
    assign inst_addr_ok = (state == S_REQ)  && (grant == G_INST) && mem_addr_ok;
    assign data_addr_ok = (state == S_REQ)  && (grant == G_DATA) && mem_addr_ok;
    assign inst_data_ok = (state == S_WAIT) && (grant == G_INST) && mem_data_ok;
    assign data_data_ok = (state == S_WAIT) && (grant == G_DATA) && mem_data_ok;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_sram_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one outstanding transaction record plus the starvation count.
    logic        tx_busy;
    logic        tx_data;
    logic        tx_accepted;
    logic        x_wr;
    logic [3:0]  x_wstrb;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    int          starve;
    logic        e_mreq, e_iaok, e_idok, e_daok, e_ddok;

    always @(negedge clk) begin
        if (!resetn) begin
            tx_busy = 1'b0; tx_data = 1'b0; tx_accepted = 1'b0;
            x_wr = 1'b0; x_wstrb = '0; x_addr = '0; x_wdata = '0;
            starve = 0;
        end
        e_mreq = resetn && tx_busy && !tx_accepted;
        e_iaok = e_mreq && mem_addr_ok && !tx_data;
        e_daok = e_mreq && mem_addr_ok &&  tx_data;
        e_idok = resetn && tx_busy && tx_accepted && mem_data_ok && !tx_data;
        e_ddok = resetn && tx_busy && tx_accepted && mem_data_ok &&  tx_data;
        check("outputs",
              {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
               inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, busy},
              {e_mreq, x_wr, x_wstrb, x_addr, x_wdata,
               e_iaok, e_idok, e_daok, e_ddok, resetn && tx_busy});
        if (e_idok) check("inst_rdata", inst_rdata, mem_rdata);
        if (e_ddok) check("data_rdata", data_rdata, mem_rdata);

        if (resetn) begin
            if (tx_busy) begin
                if (!tx_accepted) begin
                    if (mem_addr_ok) tx_accepted = 1'b1;
                end else if (mem_data_ok) begin
                    tx_busy = 1'b0;
                end
            end else if (inst_req || data_req) begin
                tx_busy = 1'b1;
                tx_accepted = 1'b0;
                if (inst_req && (!data_req || starve == int'(LIMIT))) begin
                    tx_data = 1'b0;
                    x_wr = 1'b0; x_wstrb = '0; x_addr = inst_addr; x_wdata = '0;
                    starve = 0;
                end else begin
                    tx_data = 1'b1;
                    x_wr = data_wr; x_wstrb = data_wstrb; x_addr = data_addr; x_wdata = data_wdata;
                    if (inst_req && starve < int'(LIMIT)) starve++;
                end
            end
        end
    end

    task automatic do_load(input logic [31:0] addr, input logic [31:0] rd);
        step();
        data_req = 1'b1; data_wr = 1'b0; data_wstrb = '0; data_addr = addr; data_wdata = '0;
        @(negedge clk);
        check("load_t0_mem_req", mem_req, 1'b0);
        step();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check("load_mem_req", mem_req, 1'b1);
        check("load_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
        check("load_mem_addr", mem_addr, addr);
        step();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = rd;
        @(negedge clk);
        check("load_data_ok", {inst_data_ok, data_data_ok, mem_req}, 3'b010);
        check("load_rdata", data_rdata, rd);
        step();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("load_idle", busy, 1'b0);
    endtask

    int          aok, dok, n;
    logic [9:0]  order;
    logic        acc;
    logic        i_acc, d_acc, m_acc, pend;
    int          dly;

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

        @(negedge clk);
        check("reset_state",
              {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
               inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, busy}, '0);
        step();
        resetn = 1'b1;

        // Single load, immediate accept, response next cycle.
        do_load(32'h0000_1000, 32'hDEAD_BEEF);

        // Store stalled three cycles on address acceptance.
        step();
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678;
        aok = 0; dok = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            mem_addr_ok = (i == 3);
            @(negedge clk);
            check("store_hold", {mem_req, mem_wr, mem_wstrb, mem_wdata},
                  {1'b1, 1'b1, 4'b0011, 32'h1234_5678});
            aok += int'(data_addr_ok);
        end
        step();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        @(negedge clk);
        dok += int'(data_data_ok);
        step();
        mem_data_ok = 1'b1;
        @(negedge clk);
        dok += int'(data_data_ok);
        step();
        mem_data_ok = 1'b0;
        check("store_addr_ok_count", aok, 1);
        check("store_data_ok_count", dok, 1);

        // Contention: both requesters held for ten transactions.
        inst_addr = 32'hBFC0_0100; data_addr = 32'h0000_3000; data_wr = 1'b0;
        n = 0; order = '0; acc = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (c == 0) begin inst_req = 1'b1; data_req = 1'b1; end
            mem_addr_ok = mem_req;
            mem_data_ok = acc;
            @(negedge clk);
            if (inst_addr_ok && n < 10) begin order[n] = 1'b1; n++; end
            if (data_addr_ok && n < 10) begin order[n] = 1'b0; n++; end
            acc = mem_req && mem_addr_ok;
        end
        step();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        check("grant_count", n, 10);
        check("grant_order", order, 10'h210);

        // Fetch only; payload must zero the store fields left by earlier traffic.
        step();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        step();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check("fetch_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
        check("fetch_payload", {mem_wr, mem_wstrb, mem_wdata, mem_addr},
              {1'b0, 4'b0000, 32'h0, 32'hBFC0_0000});
        step();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001;
        @(negedge clk);
        check("fetch_data_ok", {inst_data_ok, data_data_ok}, 2'b10);
        check("fetch_rdata", inst_rdata, 32'h2408_0001);
        step();
        mem_data_ok = 1'b0;

        // Reset while waiting for the response; stale response afterwards is dropped.
        step();
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_5000;
        step();
        mem_addr_ok = 1'b1;
        step();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        @(negedge clk);
        check("wait_busy", {busy, mem_req}, 2'b10);
        step();
        resetn = 1'b0;
        @(negedge clk);
        check("reset_in_wait", {mem_req, busy}, 2'b00);
        step();
        resetn = 1'b1; mem_data_ok = 1'b1;
        @(negedge clk);
        check("stale_response", {inst_data_ok, data_data_ok, busy}, 3'b000);
        step();
        mem_data_ok = 1'b0;
        do_load(32'h0000_4000, 32'hCAFE_F00D);

        // Spurious memory handshakes while idle.
        step();
        mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
        @(negedge clk);
        check("spurious_pulses", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, busy}, 5'b0);
        step();
        mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
        @(negedge clk);
        check("spurious_idle", busy, 1'b0);

        // Randomized traffic with stalls, variable response delay, spurious pulses and resets.
        pend = 1'b0; dly = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            #1;
            i_acc = inst_addr_ok; d_acc = data_addr_ok;
            m_acc = mem_req && mem_addr_ok;
            if (m_acc) begin pend = 1'b1; dly = int'($urandom_range(0, 2)); end
            step();
            if (!resetn) begin
                resetn = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                resetn = 1'b0;
                inst_req = 1'b0; data_req = 1'b0; pend = 1'b0;
                mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
                continue;
            end
            if (!inst_req || i_acc) begin
                inst_req = ($urandom_range(0, 2) == 0);
                inst_addr = $urandom;
            end
            if (!data_req || d_acc) begin
                data_req = ($urandom_range(0, 1) == 0);
                data_wr = 1'($urandom_range(0, 1));
                data_wstrb = 4'($urandom);
                data_addr = $urandom;
                data_wdata = $urandom;
            end
            mem_rdata = $urandom;
            mem_data_ok = 1'b0;
            if (pend) begin
                if (dly == 0) begin mem_data_ok = 1'b1; pend = 1'b0; end
                else dly--;
            end
            if (mem_req) mem_addr_ok = 1'($urandom_range(0, 1));
            else         mem_addr_ok = ($urandom_range(0, 7) == 0);
            if (!pend && !mem_data_ok && !(mem_req && mem_addr_ok) && $urandom_range(0, 7) == 0)
                mem_data_ok = 1'b1;
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU instruction-fetch requester and the data load/store requester.
- Sits between the CPU core/address-translation stage and the single memory/cache bridge.
- Grants one transaction at a time, with data priority bounded by a starvation limit for fetch.
- Routes handshakes and read data back to the granted requester.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants while inst_req is pending, after which fetch wins the next tie (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- inst_req  input  1  fetch request; held with inst_addr until inst_addr_ok.
- inst_addr  input  32  fetch physical address.
- inst_addr_ok  output  1  one-cycle pulse: fetch address accepted by memory.
- inst_data_ok  output  1  one-cycle pulse: inst_rdata valid.
- inst_rdata  output  32  fetch read data.
- data_req  input  1  load/store request; held with payload until data_addr_ok.
- data_wr  input  1  1 = store, 0 = load.
- data_wstrb  input  4  byte write strobes, used when data_wr=1.
- data_addr  input  32  data physical address.
- data_wdata  input  32  store data.
- data_addr_ok  output  1  one-cycle pulse: data address accepted.
- data_data_ok  output  1  one-cycle pulse: load data valid or store complete.
- data_rdata  output  32  load read data.
- mem_req  output  1  memory request, held until mem_addr_ok.
- mem_wr  output  1  write enable to memory.
- mem_wstrb  output  4  byte strobes to memory.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_addr_ok  input  1  memory accepted address this cycle.
- mem_data_ok  input  1  memory response this cycle.
- mem_rdata  input  32  memory read data, valid with mem_data_ok.
- busy  output  1  1 when state is not IDLE.

Behaviour:
- Reset (resetn=0, asynchronous) forces:
  - state=IDLE, grant=NONE, starve_cnt=0;
  - mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0;
  - all *_addr_ok and *_data_ok outputs = 0, busy=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE arbitration, evaluated each cycle:
  - data_req only: grant DATA.
  - inst_req only: grant INST.
  - Both requesting: grant DATA unless starve_cnt==STARVE_LIMIT, in which case grant INST.
  - Neither requesting: stay in IDLE.
  - On any grant, latch the granted payload into the mem_* registers and go to REQ. For INST: mem_wr=0, mem_wstrb=0, mem_wdata=0.
- starve_cnt update on each grant:
  - Increments (saturating at STARVE_LIMIT) on a DATA grant while inst_req=1.
  - Clears on an INST grant.
  - Unchanged otherwise.
- REQ state:
  - mem_req=1 with the latched payload.
  - On mem_addr_ok=1: pulse the granted requester's *_addr_ok in the same cycle (combinational from mem_addr_ok, state and grant), drop mem_req next cycle, go to WAIT.
  - Without mem_addr_ok, hold everything stable.
- WAIT state:
  - On mem_data_ok=1: pulse the granted requester's *_data_ok in the same cycle, go to IDLE, grant=NONE.
  - mem_data_ok arriving in the same cycle as mem_addr_ok while in REQ is not supported; the memory guarantees response no earlier than the cycle after address acceptance.
- Read data: inst_rdata and data_rdata are both wired to mem_rdata; they are meaningful only with the matching *_data_ok.
- Latency:
  - Request seen at cycle T → mem_req at T+1.
  - Earliest *_addr_ok at T+1, earliest *_data_ok at T+2.
  - Back-to-back transactions are issued at most one every 3 cycles; the IDLE cycle is mandatory.
- Spurious inputs:
  - mem_data_ok in IDLE or REQ is ignored, with no *_data_ok pulse. This covers stale responses after reset.
  - mem_addr_ok outside REQ is ignored.
- Reset mid-transaction:
  - Any outstanding transaction is abandoned and no pulses are issued.
  - Requesters restart their own protocol after reset.
- Non-granted requester: sees no *_addr_ok or *_data_ok until it is granted.
- Never more than one transaction is outstanding.

Test Plan:
- Single load: data_req=1, data_wr=0, addr=0x0000_1000, memory accepts immediately and returns 0xDEADBEEF one cycle later → mem_req at T+1, data_addr_ok at T+1, data_data_ok with data_rdata=0xDEADBEEF at T+2; inst_* pulses stay 0.
- Store with stall: data_wr=1, wstrb=4'b0011, wdata=0x1234_5678, mem_addr_ok held low 3 cycles → mem_req, mem_wr, mem_wstrb and mem_wdata stay stable for 4 cycles; one data_addr_ok pulse; one data_data_ok pulse.
- Contention and starvation (STARVE_LIMIT=4): inst_req and data_req held continuously → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each INST grant.
- Fetch only: inst_req=1, addr=0xBFC0_0000, response 0x2408_0001 → mem_wr=0, mem_wstrb=0; inst_data_ok with inst_rdata=0x2408_0001; data_* pulses stay 0.
- Reset in WAIT: deassert resetn while in WAIT, release, then drive mem_data_ok=1 → mem_req=0, busy=0, no *_data_ok pulse; the next data_req is served normally.
- Spurious response: mem_data_ok=1 in IDLE with no request → no pulses, state stays IDLE.
